// File: rtl/weight_frame_loader.sv
// weight_frame_loader: receives a framed stream of beamformer weight bytes,
// validates header/checksum/upper bits into a shadow bank, and copies the
// shadow bank to the active weight outputs on the next commit_tick.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | hunting for the header byte; anything else is dropped
// S_PAYLOAD | filling shadow slots, running XOR and upper-bit check
// S_CHECK   | next accepted byte is the checksum
// S_PENDING | frame validated, stalling input until commit_tick
module weight_frame_loader #(
  parameter int          NCH = 8,
  parameter int          WW  = 5,
  parameter logic [7:0]  HDR = 8'hA5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              commit_tick,
  output logic [NCH*WW-1:0] w_cos_1,
  output logic [NCH*WW-1:0] w_sin_1,
  output logic [NCH*WW-1:0] w_cos_2,
  output logic [NCH*WW-1:0] w_sin_2,
  output logic              frame_ok,
  output logic              frame_err,
  output logic              pending
);

  localparam int NSLOT = 4 * NCH;
  localparam int CW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLOT - 1);
  // Bits of a payload byte that must be zero (everything above the weight).
  localparam logic [7:0] UMASK = 8'(~((1 << WW) - 1));

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_PENDING} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      csum_q, csum_d;
  logic            err_q, err_d;
  logic [WW-1:0]   sh_q  [NSLOT];
  logic [WW-1:0]   sh_d  [NSLOT];
  logic [WW-1:0]   act_q [NSLOT];
  logic [WW-1:0]   act_d [NSLOT];
  logic            frame_ok_q, frame_ok_d;
  logic            frame_err_q, frame_err_d;
  logic            byte_ready_q, byte_ready_d;
  logic            pending_q, pending_d;
  logic            xfer;
  logic            upper_bad;

  assign xfer      = byte_valid && byte_ready_q;
  assign upper_bad = (byte_data & UMASK) != 8'h00;

  // Next-state, datapath and output computation for the frame loader.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    err_d       = err_q;
    sh_d        = sh_q;
    act_d       = act_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (xfer && byte_data == HDR) begin
          state_d = S_PAYLOAD;
          cnt_d   = '0;
          csum_d  = 8'h00;
          err_d   = 1'b0;
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          sh_d[cnt_q] = byte_data[WW-1:0];
          csum_d      = csum_q ^ byte_data;
          err_d       = err_q | upper_bad;
          if (cnt_q == LAST) begin
            state_d = S_CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_CHECK: begin
        // commit_tick is deliberately ignored here; commit needs S_PENDING.
        if (xfer) begin
          if (byte_data != csum_q || err_q) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_PENDING;
          end
          csum_d = 8'h00;
          err_d  = 1'b0;
        end
      end
      S_PENDING: begin
        if (commit_tick) begin
          act_d      = sh_q;
          frame_ok_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d != S_PENDING);
    pending_d    = (state_d == S_PENDING);
  end

  // State and bank registers; reset clears everything including active weights.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      csum_q       <= 8'h00;
      err_q        <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      byte_ready_q <= 1'b1;
      pending_q    <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        sh_q[i]  <= '0;
        act_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      csum_q       <= csum_d;
      err_q        <= err_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      byte_ready_q <= byte_ready_d;
      pending_q    <= pending_d;
      sh_q         <= sh_d;
      act_q        <= act_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign pending    = pending_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;

  // Slot 4*ch+k maps to channel ch of output k (cos1, sin1, cos2, sin2).
  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    assign w_cos_1[WW*ch +: WW] = act_q[4*ch + 0];
    assign w_sin_1[WW*ch +: WW] = act_q[4*ch + 1];
    assign w_cos_2[WW*ch +: WW] = act_q[4*ch + 2];
    assign w_sin_2[WW*ch +: WW] = act_q[4*ch + 3];
  end

endmodule

// File: doc/weight_frame_loader.md
WEIGHT_FRAME_LOADER -- requirements
Module: weight_frame_loader

Interface
REQ-001 SHALL have parameter NCH, default 8, number of beamformer channels.
REQ-002 SHALL have parameter WW, default 5, weight width in bits.
REQ-003 SHALL have parameter HDR, default 8'hA5, frame header byte.
REQ-004 clock  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 byte_valid  input  1  upstream byte strobe.
REQ-007 byte_data  input  8  upstream byte.
REQ-008 byte_ready  output  1  loader accepts byte this cycle.
REQ-009 commit_tick  input  1  one-cycle pulse marking a phase-shift sample boundary.
REQ-010 w_cos_1, w_sin_1, w_cos_2, w_sin_2  output  NCH*WW each  active weights; channel i at bits [WW*i+WW-1 : WW*i].
REQ-011 frame_ok  output  1  one-cycle pulse: frame committed to active weights.
REQ-012 frame_err  output  1  one-cycle pulse: frame discarded.
REQ-013 pending  output  1  validated frame waiting for commit_tick.

Function
REQ-014 Byte transfer SHALL occur only on cycles where byte_valid and byte_ready are both 1.
REQ-015 Frame format SHALL be: HDR, then 4*NCH payload bytes in order ch0 cos1, ch0 sin1, ch0 cos2, ch0 sin2, ch1 cos1, ..., then one checksum byte.
REQ-016 Checksum SHALL equal the XOR of all 4*NCH payload bytes; header is excluded.
REQ-017 Each payload byte's bits [WW-1:0] SHALL be written to the shadow register for its slot; bits [7:WW] SHALL be nonzero-checked.
REQ-018 States SHALL be IDLE, PAYLOAD, CHECK, PENDING.
REQ-019 IDLE: accepted byte == HDR -> PAYLOAD with slot counter 0 and running XOR 0; any other accepted byte is dropped silently and the state stays IDLE.
REQ-020 PAYLOAD: each accepted byte updates the shadow slot, the XOR and the counter; after the last slot (counter 4*NCH-1) -> CHECK.
REQ-021 CHECK: accepted byte is compared with the XOR; a mismatch or any flagged upper-bit violation -> frame_err pulse on the next cycle and IDLE; otherwise -> PENDING.
REQ-022 byte_ready SHALL be 1 in IDLE, PAYLOAD and CHECK, and 0 in PENDING.
REQ-023 pending SHALL be 1 exactly while in PENDING.
REQ-024 PENDING: on commit_tick, all shadow weights SHALL be copied to the active outputs in that same edge, frame_ok SHALL pulse the following cycle, and the state SHALL return to IDLE.
REQ-025 commit_tick outside PENDING SHALL have no effect.
REQ-026 Active outputs SHALL change only on commit; a partial or erroneous frame SHALL never alter them.
REQ-027 A commit_tick that arrives in the same cycle as the CHECK byte SHALL NOT commit; the commit occurs at the next commit_tick.
REQ-028 The shadow bank SHALL be overwritten slot-by-slot by the next frame; the active bank is independent.
REQ-029 frame_ok and frame_err SHALL never both be 1 in the same cycle.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, counter 0, XOR 0, error flag 0, all shadow and active weights 0, frame_ok 0, frame_err 0, pending 0, byte_ready 1.
REQ-031 Reset asserted mid-frame or in PENDING SHALL discard the frame without any frame_ok or frame_err pulse.

Verification
REQ-032 Good frame (NCH=8): A5, payload bytes 0x00..0x1F, checksum 0x00; commit_tick 5 cycles later -> pending high until the tick, w_cos_1 ch0=0, ch1=4, w_sin_2 ch7=0x1F, frame_ok one pulse.
REQ-033 Same frame with checksum 0x01 -> frame_err one pulse, returns to IDLE, active weights unchanged (all 0 after reset).
REQ-034 Payload byte 0x25 in slot 3 with a correct XOR -> frame_err, weights unchanged.
REQ-035 Bytes 0x11, 0x22 then a valid frame -> leading bytes ignored, frame commits normally.
REQ-036 Second valid frame presented while PENDING, byte_valid held high -> byte_ready 0, no byte consumed until the commit; second frame then accepted intact.
REQ-037 reset_n pulsed low after 10 payload bytes -> all outputs 0 asynchronously; a subsequent full frame commits correctly.
